// File: rtl/tlc_pkg.sv
// Shared types and defaults for the traffic light controller front end.
package tlc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PENDING = 2'b01,
    SERVING = 2'b10
  } car_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int CNT_W_DEF           = 8;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer, level debouncer and rising-edge detector for the
// asynchronous vehicle loop signal.
module sync_debounce
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_sensor,
  output logic stable,
  output logic rise
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync_meta;
  logic            sens_s;
  logic            stable_d;
  logic [DB_W-1:0] db_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sync_meta <= 1'b0;
      sens_s    <= 1'b0;
    end else begin
      sync_meta <= i_sensor;
      sens_s    <= sync_meta;
    end
  end

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stable <= 1'b0;
      db_cnt <= '0;
    end else if (sens_s == stable) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      stable <= sens_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stable_d <= 1'b0;
    end else begin
      stable_d <= stable;
    end
  end

  assign rise = stable & ~stable_d;

endmodule

// File: rtl/car_sensor_conditioner.sv
// Turns debounced loop arrivals into a held service request for the light
// controller. Optional arrival counter enabled by defining CAR_COUNT_EN.
module car_sensor_conditioner
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_sensor,
  input  logic             i_served,
  output logic             o_car,
  output logic             o_detect,
  output logic [CNT_W-1:0] o_car_count
);

  logic       stable;
  logic       rise;
  logic       arrival;
  car_state_t state;
  car_state_t state_nxt;
  logic       queued;
  logic       queued_nxt;

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_sensor(i_sensor),
    .stable  (stable),
    .rise    (rise)
  );

  assign arrival = rise & stable;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      queued   <= 1'b0;
      o_detect <= 1'b0;
    end else begin
      state    <= state_nxt;
      queued   <= queued_nxt;
      o_detect <= arrival;
    end
  end

  // An arrival coinciding with green release still counts as a waiting car.
  always_comb begin
    state_nxt  = state;
    queued_nxt = queued;
    case (state)
      IDLE: begin
        if (arrival) state_nxt = PENDING;
      end
      PENDING: begin
        if (i_served) begin
          state_nxt  = SERVING;
          queued_nxt = arrival;
        end
      end
      SERVING: begin
        if (!i_served) begin
          state_nxt  = (queued || arrival) ? PENDING : IDLE;
          queued_nxt = 1'b0;
        end else if (arrival) begin
          queued_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt  = IDLE;
        queued_nxt = 1'b0;
      end
    endcase
  end

  assign o_car = (state == PENDING);

`ifdef CAR_COUNT_EN
  logic [CNT_W-1:0] car_count;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      car_count <= '0;
    end else if (arrival && (car_count != '1)) begin
      car_count <= car_count + CNT_W'(1);
    end
  end

  assign o_car_count = car_count;
`else
  assign o_car_count = '0;
`endif

endmodule
